// File: rtl/mem_arbiter_if.sv
// Requester handshake and memory pin bundle for mem_arbiter.
// The slave modport is the arbiter's view; the master modport is the
// environment (requesters plus the shared Memory) driving it.
interface mem_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic              wack0;
    logic              wack1;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  mem_data_out,
        output gnt0, gnt1, rvalid0, rvalid1, wack0, wack1, rdata, busy,
        output mem_we, mem_address, mem_data_in
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output mem_data_out,
        input  gnt0, gnt1, rvalid0, rvalid1, wack0, wack1, rdata, busy,
        input  mem_we, mem_address, mem_data_in
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for the shared synchronous Memory.
// Each access takes three cycles: IDLE (sample and grant), ACCESS (memory
// pins driven, op happens at the closing edge), RESP (read data captured).
// Every output comes straight from a flop, so nothing on the requester
// side sees a combinational path from req*.
module mem_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]        reset_sync;
    logic              rst_int_n;

    logic [1:0]        state;
    logic [1:0]        next_state;
    logic              last_owner;
    logic              owner;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              take;
    logic              pick1;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    logic              gnt0_q;
    logic              gnt1_q;
    logic              rvalid0_q;
    logic              rvalid1_q;
    logic              wack0_q;
    logic              wack1_q;
    logic              busy_q;
    logic              mem_we_q;
    logic [DATA_W-1:0] rdata_q;

    // Reset enters at once but leaves on a clock edge so no flop sees a
    // release racing the clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reset_sync <= 2'b00;
        end else begin
            reset_sync <= {reset_sync[0], 1'b1};
        end
    end

    assign rst_int_n = reset_sync[1];

    // Pick the winner in IDLE: a lone requester wins, a tie goes to the
    // requester that did not own the previous access.
    always_comb begin
        take      = (state == IDLE) && (bus.req0 || bus.req1);
        pick1     = bus.req1 && (!bus.req0 || !last_owner);
        win_we    = pick1 ? bus.we1    : bus.we0;
        win_addr  = pick1 ? bus.addr1  : bus.addr0;
        win_wdata = pick1 ? bus.wdata1 : bus.wdata0;
    end

    // Sequence through the three access phases; the spare code falls back to IDLE.
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:    next_state = take ? ACCESS : IDLE;
            ACCESS:  next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State, ownership and the captured command of the winning requester.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            owner      <= 1'b0;
            cmd_we     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
        end else begin
            state <= next_state;
            if (take) begin
                owner      <= pick1;
                last_owner <= pick1;
                cmd_we     <= win_we;
                cmd_addr   <= win_addr;
                cmd_wdata  <= win_wdata;
            end
        end
    end

    // Handshake pulses and memory write strobe, registered one phase ahead
    // so each lines up with the state it belongs to.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            wack0_q   <= 1'b0;
            wack1_q   <= 1'b0;
            busy_q    <= 1'b0;
            mem_we_q  <= 1'b0;
        end else begin
            gnt0_q    <= take && !pick1;
            gnt1_q    <= take && pick1;
            busy_q    <= (next_state != IDLE);
            mem_we_q  <= take && win_we;
            rvalid0_q <= (state == RESP) && !cmd_we && !owner;
            rvalid1_q <= (state == RESP) && !cmd_we && owner;
            wack0_q   <= (state == RESP) && cmd_we && !owner;
            wack1_q   <= (state == RESP) && cmd_we && owner;
        end
    end

    // Read data is taken from the memory at the end of RESP and otherwise
    // held, so writes leave the last read result untouched.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            rdata_q <= '0;
        end else if ((state == RESP) && !cmd_we) begin
            rdata_q <= bus.mem_data_out;
        end
    end

    assign bus.gnt0        = gnt0_q;
    assign bus.gnt1        = gnt1_q;
    assign bus.rvalid0     = rvalid0_q;
    assign bus.rvalid1     = rvalid1_q;
    assign bus.wack0       = wack0_q;
    assign bus.wack1       = wack1_q;
    assign bus.busy        = busy_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_address = cmd_addr;
    assign bus.mem_data_in = cmd_wdata;
    assign bus.rdata       = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a 16x8 synchronous memory model, a high-level
// reference (memory image plus grant history) and one task per scenario.
module tb_mem_arbiter;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Shared synchronous memory with a bench-only preload port.
    logic [7:0] mem [16];
    logic       pre_we = 1'b0;
    logic [3:0] pre_addr = '0;
    logic [7:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (bus.mem_we) mem[bus.mem_address] <= bus.mem_data_in;
        bus.mem_data_out <= mem[bus.mem_address];
    end

    // Reference state: expected memory image, grant history, last read value.
    logic [7:0] ref_mem [16];
    int         grant_log[$];
    logic [7:0] ref_rdata;

    int compared = 0;
    int mismatched = 0;

    typedef struct packed {
        logic       gnt0;
        logic       gnt1;
        logic       rvalid0;
        logic       rvalid1;
        logic       wack0;
        logic       wack1;
        logic       busy;
        logic       mem_we;
        logic [3:0] mem_address;
        logic [7:0] mem_data_in;
        logic [7:0] rdata;
    } snap_t;

    snap_t s1, s2, s3;

    function automatic snap_t snap();
        snap_t s;
        s.gnt0 = bus.gnt0;        s.gnt1 = bus.gnt1;
        s.rvalid0 = bus.rvalid0;  s.rvalid1 = bus.rvalid1;
        s.wack0 = bus.wack0;      s.wack1 = bus.wack1;
        s.busy = bus.busy;        s.mem_we = bus.mem_we;
        s.mem_address = bus.mem_address;
        s.mem_data_in = bus.mem_data_in;
        s.rdata = bus.rdata;
        return s;
    endfunction

    // Tie winner from the grant history: requester 0 first after reset,
    // otherwise whoever did not own the last access.
    function automatic int tie_winner();
        if (grant_log.size() == 0) return 0;
        return 1 - grant_log[$];
    endfunction

    task automatic preload(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic set_req0(input logic r, input logic w, input logic [3:0] a, input logic [7:0] d);
        bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
    endtask

    task automatic set_req1(input logic r, input logic w, input logic [3:0] a, input logic [7:0] d);
        bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    endtask

    // Samples the three cycles of one access, starting from a negedge in IDLE
    // with requests already driven.
    task automatic run_txn(input bit keep);
        @(negedge clk); s1 = snap();
        if (!keep) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
        @(negedge clk); s2 = snap();
        @(negedge clk); s3 = snap();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        grant_log.delete();
        ref_rdata = 8'h00;
    endtask

    task automatic test_reset();
        snap_t s;
        set_req0(1'b0, 1'b0, 4'd0, 8'd0);
        set_req1(1'b0, 1'b0, 4'd0, 8'd0);
        for (int a = 0; a < 16; a++) preload(a[3:0], 8'($urandom));
        preload(4'd5, 8'h3C);
        preload(4'd3, 8'h11);
        s = snap();
        compared++; if (s !== '0) begin mismatched++; $display("[TB] FAIL reset_outputs: got %h expected 0", s); end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        s = snap();
        compared++; if (s !== '0) begin mismatched++; $display("[TB] FAIL reset_release_outputs: got %h expected 0", s); end
        grant_log.delete();
        ref_rdata = 8'h00;
    endtask

    task automatic test_idle();
        snap_t s;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); s = snap();
            compared++;
            if ({s.gnt0, s.gnt1, s.rvalid0, s.rvalid1, s.wack0, s.wack1, s.busy, s.mem_we} !== 8'h00) begin
                mismatched++;
                $display("[TB] FAIL idle_cycle%0d: got flags %b expected 00000000", i,
                         {s.gnt0, s.gnt1, s.rvalid0, s.rvalid1, s.wack0, s.wack1, s.busy, s.mem_we});
            end
        end
    endtask

    task automatic test_read();
        set_req0(1'b1, 1'b0, 4'd5, 8'h00);
        run_txn(1'b0);
        grant_log.push_back(0);
        ref_rdata = ref_mem[5];
        compared++; if ({s1.gnt0, s1.gnt1, s1.busy} !== 3'b101) begin mismatched++; $display("[TB] FAIL read_grant: got gnt0,gnt1,busy=%b expected 101", {s1.gnt0, s1.gnt1, s1.busy}); end
        compared++; if (s1.mem_address !== 4'd5) begin mismatched++; $display("[TB] FAIL read_address: got %0d expected 5", s1.mem_address); end
        compared++; if ({s2.gnt0, s2.busy, s2.mem_we} !== 3'b010) begin mismatched++; $display("[TB] FAIL read_resp_phase: got gnt0,busy,mem_we=%b expected 010", {s2.gnt0, s2.busy, s2.mem_we}); end
        compared++; if ({s3.rvalid0, s3.rvalid1, s3.busy} !== 3'b100) begin mismatched++; $display("[TB] FAIL read_rvalid: got rvalid0,rvalid1,busy=%b expected 100", {s3.rvalid0, s3.rvalid1, s3.busy}); end
        compared++; if (s3.rdata !== 8'h3C) begin mismatched++; $display("[TB] FAIL read_rdata: got %h expected 3c", s3.rdata); end
    endtask

    task automatic test_write_readback();
        int we_cycles;
        set_req1(1'b1, 1'b1, 4'd15, 8'hA5);
        run_txn(1'b0);
        grant_log.push_back(1);
        ref_mem[15] = 8'hA5;
        we_cycles = int'(s1.mem_we) + int'(s2.mem_we) + int'(s3.mem_we);
        compared++; if ({s1.gnt0, s1.gnt1} !== 2'b01) begin mismatched++; $display("[TB] FAIL write_grant: got gnt0,gnt1=%b expected 01", {s1.gnt0, s1.gnt1}); end
        compared++; if ({s1.mem_address, s1.mem_data_in} !== {4'd15, 8'hA5}) begin mismatched++; $display("[TB] FAIL write_pins: got addr %0d data %h expected 15 a5", s1.mem_address, s1.mem_data_in); end
        compared++; if (we_cycles != 1) begin mismatched++; $display("[TB] FAIL write_we_cycles: got %0d expected 1", we_cycles); end
        compared++; if ({s3.wack0, s3.wack1, s3.rvalid1} !== 3'b010) begin mismatched++; $display("[TB] FAIL write_wack: got wack0,wack1,rvalid1=%b expected 010", {s3.wack0, s3.wack1, s3.rvalid1}); end
        compared++; if (s3.rdata !== ref_rdata) begin mismatched++; $display("[TB] FAIL write_keeps_rdata: got %h expected %h", s3.rdata, ref_rdata); end
        compared++; if (mem[15] !== 8'hA5) begin mismatched++; $display("[TB] FAIL write_mem15: got %h expected a5", mem[15]); end
        set_req0(1'b1, 1'b0, 4'd15, 8'h00);
        run_txn(1'b0);
        grant_log.push_back(0);
        ref_rdata = 8'hA5;
        compared++; if ({s3.rvalid0, s3.rdata} !== {1'b1, 8'hA5}) begin mismatched++; $display("[TB] FAIL readback: got rvalid0 %b rdata %h expected 1 a5", s3.rvalid0, s3.rdata); end
    endtask

    task automatic test_tie_after_reset();
        logic [3:0] a0, a1;
        int win;
        do_reset();
        a0 = 4'($urandom); a1 = 4'($urandom);
        set_req0(1'b1, 1'b0, a0, 8'h00);
        set_req1(1'b1, 1'b0, a1, 8'h00);
        for (int k = 0; k < 4; k++) begin
            win = tie_winner();
            run_txn(1'b1);
            grant_log.push_back(win);
            ref_rdata = ref_mem[win == 0 ? a0 : a1];
            compared++; if ({s1.gnt0, s1.gnt1} !== (win == 0 ? 2'b10 : 2'b01)) begin mismatched++; $display("[TB] FAIL tie_grant%0d: got gnt0,gnt1=%b expected winner %0d", k, {s1.gnt0, s1.gnt1}, win); end
            compared++; if ({s3.rvalid0, s3.rvalid1, s3.rdata} !== {win == 0, win == 1, ref_rdata}) begin mismatched++; $display("[TB] FAIL tie_resp%0d: got rvalid %b%b rdata %h expected winner %0d rdata %h", k, s3.rvalid0, s3.rvalid1, s3.rdata, win, ref_rdata); end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_withdrawal();
        snap_t s;
        logic [3:0] a;
        a = 4'($urandom);
        set_req0(1'b1, 1'b0, a, 8'h00);
        @(negedge clk); s1 = snap();
        bus.req0 = 1'b0;
        set_req1(1'b1, 1'($urandom), 4'($urandom), 8'($urandom));
        @(negedge clk);
        bus.req1 = 1'b0;
        @(negedge clk); s3 = snap();
        grant_log.push_back(0);
        ref_rdata = ref_mem[a];
        compared++; if ({s1.gnt0, s1.gnt1} !== 2'b10) begin mismatched++; $display("[TB] FAIL withdraw_first_grant: got gnt0,gnt1=%b expected 10", {s1.gnt0, s1.gnt1}); end
        compared++; if ({s3.rvalid0, s3.gnt1, s3.rdata} !== {1'b1, 1'b0, ref_rdata}) begin mismatched++; $display("[TB] FAIL withdraw_resp: got rvalid0 %b gnt1 %b rdata %h expected 1 0 %h", s3.rvalid0, s3.gnt1, s3.rdata, ref_rdata); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); s = snap();
            compared++; if ({s.gnt0, s.gnt1, s.busy, s.mem_we} !== 4'b0000) begin mismatched++; $display("[TB] FAIL withdraw_idle%0d: got gnt0,gnt1,busy,mem_we=%b expected 0000", i, {s.gnt0, s.gnt1, s.busy, s.mem_we}); end
        end
    endtask

    task automatic test_reset_during_write();
        snap_t s;
        preload(4'd3, 8'h11);
        set_req0(1'b1, 1'b1, 4'd3, 8'h77);
        @(negedge clk); s1 = snap();
        bus.req0 = 1'b0;
        compared++; if (s1.mem_we !== 1'b1) begin mismatched++; $display("[TB] FAIL abort_we_before: got %b expected 1", s1.mem_we); end
        reset = 1'b0;
        #1;
        compared++; if (bus.mem_we !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_we_drop: got %b expected 0", bus.mem_we); end
        s = snap();
        compared++; if (s !== '0) begin mismatched++; $display("[TB] FAIL abort_outputs: got %h expected 0", s); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) reset = 1'b1;
            s = snap();
            compared++; if (s !== '0) begin mismatched++; $display("[TB] FAIL abort_quiet%0d: got %h expected 0", i, s); end
        end
        grant_log.delete();
        ref_rdata = 8'h00;
        compared++; if (mem[3] !== 8'h11) begin mismatched++; $display("[TB] FAIL abort_mem3: got %h expected 11", mem[3]); end
        set_req0(1'b1, 1'b0, 4'd3, 8'h00);
        run_txn(1'b0);
        grant_log.push_back(0);
        ref_rdata = 8'h11;
        compared++; if ({s3.rvalid0, s3.rdata} !== {1'b1, 8'h11}) begin mismatched++; $display("[TB] FAIL abort_readback: got rvalid0 %b rdata %h expected 1 11", s3.rvalid0, s3.rdata); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic r0, r1, w0, w1, ww;
            logic [3:0] a0, a1, wa;
            logic [7:0] d0, d1, wd;
            logic [3:0] exp_resp;
            int win;
            r0 = 1'($urandom); r1 = 1'($urandom);
            w0 = 1'($urandom); w1 = 1'($urandom);
            a0 = 4'($urandom); a1 = 4'($urandom);
            d0 = 8'($urandom); d1 = 8'($urandom);
            if (!r0 && !r1) begin
                @(negedge clk);
                compared++; if ({bus.busy, bus.gnt0, bus.gnt1} !== 3'b000) begin mismatched++; $display("[TB] FAIL rand%0d_idle: got busy,gnt0,gnt1=%b expected 000", i, {bus.busy, bus.gnt0, bus.gnt1}); end
                continue;
            end
            win = (r0 && r1) ? tie_winner() : (r1 ? 1 : 0);
            ww = (win == 0) ? w0 : w1;
            wa = (win == 0) ? a0 : a1;
            wd = (win == 0) ? d0 : d1;
            set_req0(r0, w0, a0, d0);
            set_req1(r1, w1, a1, d1);
            run_txn(1'b0);
            grant_log.push_back(win);
            if (ww) begin
                ref_mem[wa] = wd;
                exp_resp = (win == 0) ? 4'b0010 : 4'b0001;
            end else begin
                ref_rdata = ref_mem[wa];
                exp_resp = (win == 0) ? 4'b1000 : 4'b0100;
            end
            compared++; if ({s1.gnt0, s1.gnt1} !== (win == 0 ? 2'b10 : 2'b01)) begin mismatched++; $display("[TB] FAIL rand%0d_grant: got gnt0,gnt1=%b expected winner %0d", i, {s1.gnt0, s1.gnt1}, win); end
            compared++; if ({s1.mem_we, s1.mem_address} !== {ww, wa}) begin mismatched++; $display("[TB] FAIL rand%0d_pins: got we %b addr %0d expected we %b addr %0d", i, s1.mem_we, s1.mem_address, ww, wa); end
            if (ww) begin
                compared++; if (s1.mem_data_in !== wd) begin mismatched++; $display("[TB] FAIL rand%0d_wdata: got %h expected %h", i, s1.mem_data_in, wd); end
            end
            compared++; if ({s1.rvalid0, s1.rvalid1, s1.wack0, s1.wack1} !== 4'b0000) begin mismatched++; $display("[TB] FAIL rand%0d_no_early_resp: got %b expected 0000", i, {s1.rvalid0, s1.rvalid1, s1.wack0, s1.wack1}); end
            compared++; if ({s3.rvalid0, s3.rvalid1, s3.wack0, s3.wack1} !== exp_resp) begin mismatched++; $display("[TB] FAIL rand%0d_resp: got %b expected %b", i, {s3.rvalid0, s3.rvalid1, s3.wack0, s3.wack1}, exp_resp); end
            compared++; if ({s3.rdata, s3.busy} !== {ref_rdata, 1'b0}) begin mismatched++; $display("[TB] FAIL rand%0d_rdata: got %h busy %b expected %h busy 0", i, s3.rdata, s3.busy, ref_rdata); end
        end
        for (int a = 0; a < 16; a++) begin
            compared++; if (mem[a] !== ref_mem[a]) begin mismatched++; $display("[TB] FAIL rand_mem%0d: got %h expected %h", a, mem[a], ref_mem[a]); end
        end
    endtask

    initial begin
        $display("[TB] mem_arbiter bench start");
        test_reset();
        test_idle();
        test_read();
        test_write_readback();
        test_tie_after_reset();
        test_withdrawal();
        test_reset_during_write();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter for the shared 16x8 synchronous `Memory` in the IAS design. It serialises accesses from the CPU control unit (requester 0) and a loader/debug port (requester 1) using a registered req/gnt handshake with round-robin fairness. It drives the memory's `we`/`address`/`data_in` pins and returns read data to the winning requester. One memory access completes every 3 cycles.

## Interface
- `ADDR_W`, default 4: memory address width; the memory has 2^ADDR_W locations.
- `DATA_W`, default 8: memory data width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset. Low immediately forces the reset state; it is released synchronously by the design.
- `req0`, `req1` in 1: access request from requester 0 / requester 1.
- `we0`, `we1` in 1: 1 = write, 0 = read. Qualified by the matching `req`.
- `addr0`, `addr1` in ADDR_W: access address.
- `wdata0`, `wdata1` in DATA_W: write data.
- `gnt0`, `gnt1` out 1: one-cycle pulse; the request has been accepted and its fields captured.
- `rvalid0`, `rvalid1` out 1: one-cycle pulse; `rdata` holds the read result for that requester.
- `wack0`, `wack1` out 1: one-cycle pulse; the write has been committed to memory.
- `rdata` out DATA_W: read data. It is shared between requesters and is valid only when an `rvalid` is high.
- `busy` out 1: high whenever the state is not IDLE.
- `mem_we` out 1: drives `Memory.we`.
- `mem_address` out ADDR_W: drives `Memory.address`.
- `mem_data_in` out DATA_W: drives `Memory.data_in`.
- `mem_data_out` in DATA_W: driven by `Memory.data_out`.

## Operation
- The FSM has three states, IDLE → ACCESS → RESP → IDLE, with no other transitions. The state encoding is 2 bits; the unused code returns to IDLE.
- **IDLE**
  - If no `req` is high, stay in IDLE.
  - If exactly one `req` is high, that requester wins.
  - If both are high, the requester other than `last_owner` wins.
  - On the winning edge: capture `we`, `addr` and `wdata` into command registers, set `owner`, set `last_owner` to the winner, pulse that requester's `gnt`, and go to ACCESS.
- **ACCESS**
  - Drive `mem_we` = captured `we`, `mem_address` = captured `addr`, `mem_data_in` = captured `wdata`.
  - The memory performs the operation at the end of this cycle. Go to RESP.
- **RESP**
  - Force `mem_we` to 0; hold `mem_address`.
  - At the end of the cycle:
    - For a read: register `mem_data_out` into `rdata` and pulse `rvalid[owner]` in the following cycle.
    - For a write: pulse `wack[owner]` in the following cycle.
  - Go to IDLE.
- `mem_we` is 1 only in ACCESS with a captured write. It is 0 in every other state and during reset.
- Requesters hold `req`, `we`, `addr` and `wdata` stable until `gnt`.
- After `gnt`, the request fields are don't-care. A `req` still high in the next IDLE cycle counts as a new request.
- Dropping `req` before `gnt` withdraws the request; no access occurs.
- `rdata` holds its last value until the next read completes. Writes do not change it.
- Addresses use the full ADDR_W range (0..15). There is no wrap or bounds logic.

## Timing
- Reset state: FSM = IDLE, `last_owner` = 1 (so requester 0 wins the first tie), and the command registers are 0.
- Every output is 0 in reset: all `gnt`, `rvalid`, `wack`, `busy`, `mem_we`, `mem_address`, `mem_data_in`, `rdata`.
- All outputs are registered; none depends combinationally on `req*`.
- Cycle timing for a request sampled at edge E0 in IDLE:
  - `gnt` and `busy` are high in cycle E0–E1.
  - The memory op occurs at E1.
  - Data is captured at E2.
  - `rvalid`/`wack` is high in cycle E2–E3, during which the FSM is back in IDLE and `busy` = 0.
- Read latency is 3 edges from request sample to `rvalid`. Back-to-back requests are sampled every 3 cycles.
- A `req` arriving during ACCESS or RESP waits; it is evaluated in the next IDLE cycle.
- If both requesters hold `req` continuously, grants alternate 0, 1, 0, 1, …
- Reset asserted mid-operation aborts the access immediately:
  - If asserted during ACCESS with a write, `mem_we` drops asynchronously, so the write is lost.
  - No `rvalid`/`wack` is issued for the aborted access.

## Test plan
- Read: preload mem[5] = 0x3C; `req0` = 1, `we0` = 0, `addr0` = 5 → `gnt0` 1 cycle later; `rvalid0` with `rdata` = 0x3C three edges after the request sample; `rvalid1` stays 0.
- Write then readback: requester 1 writes 0xA5 to address 15 → `wack1` pulses; then requester 0 reads address 15 → `rdata` = 0xA5; `mem_we` is high for exactly 1 cycle.
- Tie after reset: `req0` and `req1` rise in the same cycle → `gnt0` first, then `gnt1` in the next IDLE; both hold `req` for 4 grants → sequence 0, 1, 0, 1.
- Withdrawal and wait: `req1` raised during ACCESS of a requester-0 access, then dropped before IDLE → no `gnt1`, FSM stays in IDLE, `mem_we` = 0.
- Reset during write: drive `reset` low in the ACCESS cycle of a write of 0x77 to address 3 (mem[3] = 0x11) → `mem_we` = 0 immediately, mem[3] still reads 0x11 after release, no `wack`, all outputs 0.
- Idle check: no requests for 20 cycles → `busy`, `mem_we`, all `gnt`/`rvalid`/`wack` remain 0.
